serial_subtractor: RTL

- Bit-serial N-bit subtractor that computes A − B, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow flop.
- It is the inverse-direction arithmetic counterpart of the team's adder blocks, trading latency for area.
- Sits behind a start/done handshake so a controller can issue operations and collect a registered difference and final borrow.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 92 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state codes and default operand width.
package arith_pkg;

   localparam int DEF_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (a - b - bin), built from two half-subtractor stages.
// Purely combinational, no latency, no backpressure.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   assign w_d1 = a ^ b;
   assign w_b1 = ~a & b;
   assign d    = w_d1 ^ bin;
   assign w_b2 = ~w_d1 & bin;
   assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first; result WIDTH+1 cycles after an accepted start.
// start is ignored while busy; a start during the done cycle is accepted back-to-back.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_br;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;

   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_next;
   logic             w_last;

   full_subtractor u_fs (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_bout)
   );

   // New bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_res   <= '0;
                  r_br    <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= w_res_next;
               r_br  <= w_bout;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_diff   <= w_res_next;
                  r_borrow <= w_bout;
                  r_state  <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;
   assign busy   = (r_state == ST_RUN);
   assign done   = (r_state == ST_DONE);

endmodule
